// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants: ID/EX payload widths, field layout and NOP encodings.
package pipe_pkg;

    localparam int unsigned IDEX_CTRL_W = 8;
    localparam int unsigned IDEX_DATA_W = 96;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [3:0] alu_op;
    } idex_ctrl_t;

    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } idex_data_t;

    // NOP must never write state: all enables low, ALU op don't-care.
    localparam idex_ctrl_t IDEX_CTRL_NOP = '0;

    function automatic logic is_idex_nop(input idex_ctrl_t c);
        return ~(c.reg_write | c.mem_read | c.mem_write | c.branch);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register for pipe_stage_reg; forwards the older skid item ahead of upstream.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = IDEX_CTRL_W,
    parameter int unsigned DATA_W = IDEX_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_adv,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_skid_v,
    output logic              o_sel_valid,
    output logic [CTRL_W-1:0] o_sel_ctrl,
    output logic [DATA_W-1:0] o_sel_data
);

    logic              r_skid_v;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_skid_v    <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (i_flush) begin
            r_skid_v <= 1'b0;
        end else if (i_stall) begin
            r_skid_v <= r_skid_v;
        end else if (i_adv && r_skid_v) begin
            r_skid_v <= 1'b0;
        end else if (i_load) begin
            r_skid_v    <= 1'b1;
            r_skid_ctrl <= i_ctrl;
            r_skid_data <= i_data;
        end
    end

    assign o_skid_v    = r_skid_v;
    assign o_sel_valid = r_skid_v ? 1'b1 : i_valid;
    assign o_sel_ctrl  = r_skid_v ? r_skid_ctrl : i_ctrl;
    assign o_sel_data  = r_skid_v ? r_skid_data : i_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with valid/ready, stall, flush and bubble insertion.
// Define PIPE_SKID_EN to add a skid entry that cuts the ready_i -> ready_o path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = IDEX_CTRL_W,
    parameter int unsigned       DATA_W      = IDEX_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    logic              w_adv;
    logic              w_nop;
    logic              w_sel_valid;
    logic [CTRL_W-1:0] w_sel_ctrl;
    logic [DATA_W-1:0] w_sel_data;

    assign w_adv = ~stall_i & (~r_valid | ready_i);

`ifdef PIPE_SKID_EN
    logic w_skid_v;

    assign ready_o = ~w_skid_v & ~stall_i & ~bubble_i;

    pipe_skid_buf #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_flush    (flush_i),
        .i_stall    (stall_i),
        .i_adv      (w_adv),
        .i_load     (valid_i & ready_o & ~w_adv),
        .i_valid    (valid_i),
        .i_ctrl     (ctrl_i),
        .i_data     (data_i),
        .o_skid_v   (w_skid_v),
        .o_sel_valid(w_sel_valid),
        .o_sel_ctrl (w_sel_ctrl),
        .o_sel_data (w_sel_data)
    );

    // A parked skid item is older than the hazard, so it drains instead of a NOP.
    assign w_nop = bubble_i & ~w_skid_v;
`else
    assign ready_o     = ~stall_i & ~bubble_i & (~r_valid | ready_i);
    assign w_sel_valid = valid_i;
    assign w_sel_ctrl  = ctrl_i;
    assign w_sel_data  = data_i;
    assign w_nop       = bubble_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
            r_data  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (stall_i) begin
            r_valid <= r_valid;
        end else if (w_adv && w_nop) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (w_adv) begin
            r_valid <= w_sel_valid;
            r_ctrl  <= w_sel_valid ? w_sel_ctrl : CTRL_BUBBLE;
            r_data  <= w_sel_data;
        end
    end

    assign valid_o = r_valid;
    assign ctrl_o  = r_ctrl;
    assign data_o  = r_data;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, global stall, flush and hazard-bubble insertion. It is the common successor for every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB): the control and data payloads are generic vectors. The block sits between two pipeline stages, and the hazard unit and memory-stall logic drive its stall, flush and bubble inputs. An optional skid buffer removes the combinational ready_i→ready_o path.

## Interface
- CTRL_W, 8: control payload width; cleared to CTRL_BUBBLE on bubble/flush.
- DATA_W, 96: data payload width (operands, immediate, addresses); never cleared except by reset.
- CTRL_BUBBLE, '0: control value representing a NOP.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  global freeze (e.g. memory stall); holds every register.
- flush_i  in  1  kill current contents (branch/exception).
- bubble_i  in  1  hazard: insert NOP downstream, hold upstream.
- valid_i  in  1  upstream item valid.
- ctrl_i  in  CTRL_W  upstream control payload.
- data_i  in  DATA_W  upstream data payload.
- ready_o  out  1  stage accepts an item this cycle.
- valid_o  out  1  downstream item valid.
- ctrl_o  out  CTRL_W  registered control.
- data_o  out  DATA_W  registered data.
- ready_i  in  1  downstream accepts.

## Operation
- Reset: valid_o=0, ctrl_o=CTRL_BUBBLE, data_o=0, ready_o reflects the empty state (1 if stall_i=0 and bubble_i=0). Skid buffer is emptied.
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i.
- Advance condition: adv = ~stall_i & (~valid_o | ready_i).
- Update priority:
  - rst_i.
  - flush_i: valid_o←0 and ctrl_o←CTRL_BUBBLE, even when stall_i=1. data_o is held. The skid buffer is emptied. An item accepted in the same cycle is dropped.
  - stall_i: hold all state.
  - bubble_i with adv: load a NOP (valid_o←0, ctrl_o←CTRL_BUBBLE, data_o held).
  - adv: load valid_i. ctrl_o←ctrl_i if valid_i else CTRL_BUBBLE. data_o←data_i.
  - Otherwise: hold.
- ready_o = ~stall_i & ~bubble_i & (~valid_o | ready_i). This path is combinational from ready_i.
- Simultaneous flush_i & bubble_i: flush wins; the result is identical (empty).

## Timing
- Latency: 1 cycle from transfer in to valid_o.
- Throughput: 1 item/cycle while ready_i=1.
- Bubble: a one-cycle pulse gives exactly one NOP downstream. Upstream sees ready_o=0 for that cycle and must hold its payload.
- valid_o never drops without a transfer out, unless flush_i or rst_i occurs.
- Reset asserted mid-transfer: state clears immediately (async). The first transfer in is possible in the first cycle after deassertion.

## Configuration
- PIPE_SKID_EN defined: a 2-entry arrangement (main register plus one skid register).
  - ready_o = ~skid_v_q & ~stall_i & ~bubble_i, with no path from ready_i.
  - An accepted item goes to main if adv, otherwise to skid.
  - On adv with skid valid: main←skid and skid clears. This also applies under bubble_i, because the skid item is older and no NOP is needed.
  - Latency is unchanged; one extra cycle of buffering.
- PIPE_SKID_EN undefined: single register, combinational ready_o as above, and no skid state is synthesised.

## Structure
- Shared package pipe_pkg holds the per-stage width constants (ID/EX CTRL_W and DATA_W field layout) and NOP control encodings, so every instantiation uses common values.
- One sub-module, pipe_skid_buf (skid register plus select logic), is instantiated only under PIPE_SKID_EN.

## Test plan
- Reset, then stream 4 items (ctrl=8'h11..8'h14) with ready_i=1 → each appears on valid_o/ctrl_o one cycle after its transfer in; ready_o stays 1 throughout.
- Item A held with ready_i=0 for 3 cycles → valid_o=1, ctrl_o and data_o stable, ready_o=0 (no skid). With skid: one extra item is accepted, then ready_o=0.
- bubble_i pulsed 1 cycle while upstream holds B → one cycle with valid_o=0 and ctrl_o=CTRL_BUBBLE, then B appears; B is never duplicated or lost.
- stall_i=1 for 2 cycles with valid_i=1 and ready_i=1 → outputs frozen and ready_o=0; flow resumes in order afterwards.
- flush_i with stall_i=1 and skid full → next cycle valid_o=0, ctrl_o=CTRL_BUBBLE, skid empty, data_o unchanged.
- rst_i asserted asynchronously mid-stream → outputs reach their reset values before the next edge; streaming restarts cleanly after release.
